// File: rtl/prach_fft3_sched.sv
// Scheduler that time-shares one 3-point DIT FFT datapath between two
// requesters. Each grant moves one 3-sample block. A small tag FIFO records
// which requester owns each block in flight, so every result triple leaving
// the FFT can be labelled with its owner.
//
// Handshake: a sample moves on a rising edge where reqk_valid && reqk_ready.
// reqk_ready depends only on the registered FSM state, never on reqk_valid.
// A requester holds its sample stable until that edge, and may drop valid
// between samples without losing its grant.
module prach_fft3_sched #(
    parameter int TAG_DEPTH = 4,
    parameter int NUM_REQ   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [17:0] req0_dr,
    input  logic [17:0] req0_di,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [17:0] req1_dr,
    input  logic [17:0] req1_di,
    input  logic        req1_valid,
    output logic        req1_ready,
    output logic [17:0] fft_din_dr,
    output logic [17:0] fft_din_di,
    output logic        fft_din_dv,
    output logic        fft_sync_in,
    input  logic [17:0] fft_dout_dr,
    input  logic [17:0] fft_dout_di,
    input  logic        fft_dout_dv,
    input  logic        fft_sync_out,
    output logic [17:0] res_dr,
    output logic [17:0] res_di,
    output logic        res_dv,
    output logic        res_sync,
    output logic        res_id,
    output logic        err_orphan,
    output logic [1:0]  fsm_state
);

    localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int PTR_W = $clog2(TAG_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY0 = 2'd1,
        BUSY1 = 2'd2
    } state_t;

    state_t           state;
    logic             prio;      // requester that wins when both are valid
    logic [1:0]       in_cnt;    // index of the next sample to accept in the block
    logic [1:0]       out_cnt;   // index expected for the next FFT output sample

    logic [ID_W-1:0]  tag_mem [TAG_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   tag_cnt;

    logic             tag_full;
    logic             tag_empty;
    logic             grant_req;
    logic             grant_id;
    logic             in_acc;
    logic             pop;
    logic [1:0]       out_idx;

    assign tag_full   = (tag_cnt == (PTR_W+1)'(TAG_DEPTH));
    assign tag_empty  = (tag_cnt == '0);
    assign req0_ready = (state == BUSY0);
    assign req1_ready = (state == BUSY1);
    assign in_acc     = (req0_ready && req0_valid) || (req1_ready && req1_valid);
    assign fsm_state  = state;

    // A sync from the FFT restarts the output count, so a stray sample cannot
    // misalign the triples that follow it.
    assign out_idx = fft_sync_out ? 2'd0 : out_cnt;
    assign pop     = fft_dout_dv && !tag_empty && (out_idx == 2'd2);

    // Grant decision in IDLE: round robin on contention, blocked while the tag FIFO is full.
    always_comb begin
        grant_req = 1'b0;
        grant_id  = 1'b0;
        if (state == IDLE && !tag_full) begin
            if (req0_valid && req1_valid) begin
                grant_req = 1'b1;
                grant_id  = prio;
            end else if (req0_valid) begin
                grant_req = 1'b1;
                grant_id  = 1'b0;
            end else if (req1_valid) begin
                grant_req = 1'b1;
                grant_id  = 1'b1;
            end
        end
    end

    // Block FSM: hold the grant until the third accepted sample of the block.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            prio   <= 1'b0;
            in_cnt <= 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_req) begin
                        state <= grant_id ? BUSY1 : BUSY0;
                        prio  <= ~grant_id;
                    end
                end
                BUSY0, BUSY1: begin
                    if (in_acc) begin
                        if (in_cnt == 2'd2) begin
                            in_cnt <= 2'd0;
                            state  <= IDLE;
                        end else begin
                            in_cnt <= in_cnt + 2'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Register accepted samples toward the FFT; data holds when nothing is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fft_din_dr  <= '0;
            fft_din_di  <= '0;
            fft_din_dv  <= 1'b0;
            fft_sync_in <= 1'b0;
        end else begin
            fft_din_dv  <= in_acc;
            fft_sync_in <= in_acc && (in_cnt == 2'd0);
            if (in_acc) begin
                fft_din_dr <= (state == BUSY1) ? req1_dr : req0_dr;
                fft_din_di <= (state == BUSY1) ? req1_di : req0_di;
            end
        end
    end

    // Tag FIFO: push the owner on each grant, pop after the third output sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            tag_cnt <= '0;
            for (int i = 0; i < TAG_DEPTH; i++) begin
                tag_mem[i] <= '0;
            end
        end else begin
            if (grant_req) begin
                tag_mem[wr_ptr] <= ID_W'(grant_id);
                wr_ptr          <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({grant_req, pop})
                2'b10:   tag_cnt <= tag_cnt + 1'b1;
                2'b01:   tag_cnt <= tag_cnt - 1'b1;
                default: tag_cnt <= tag_cnt;
            endcase
        end
    end

    // Result stage: label each FFT output with its owner and flag outputs that have no owner.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_dr     <= '0;
            res_di     <= '0;
            res_dv     <= 1'b0;
            res_sync   <= 1'b0;
            res_id     <= 1'b0;
            out_cnt    <= 2'd0;
            err_orphan <= 1'b0;
        end else begin
            res_dv   <= fft_dout_dv;
            res_sync <= fft_dout_dv && fft_sync_out;
            if (fft_dout_dv) begin
                res_dr  <= fft_dout_dr;
                res_di  <= fft_dout_di;
                res_id  <= tag_empty ? 1'b0 : tag_mem[rd_ptr][0];
                out_cnt <= (out_idx == 2'd2) ? 2'd0 : out_idx + 2'd1;
                if (tag_empty) begin
                    err_orphan <= 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/prach_fft3_sched.md
PRACH_FFT3_SCHED -- requirements
Module: prach_fft3_sched

Interface
REQ-001 SHALL have parameter TAG_DEPTH, default 4, depth of the block-ID tag FIFO (power of 2, >= 2).
REQ-002 SHALL have parameter NUM_REQ, fixed 2, number of requesters sharing one 3-point DIT FFT datapath.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports req0_dr/req0_di, req1_dr/req1_di  input  18 each  requester I/Q samples, two's complement.
REQ-006 SHALL have ports req0_valid, req1_valid  input  1  sample offered; req0_ready, req1_ready  output  1  sample accepted when valid&&ready.
REQ-007 SHALL have ports fft_din_dr, fft_din_di  output  18, fft_din_dv  output  1, fft_sync_in  output  1  drive to the FFT3 datapath.
REQ-008 SHALL have ports fft_dout_dr, fft_dout_di  input  18, fft_dout_dv  input  1, fft_sync_out  input  1  return from the FFT3 datapath.
REQ-009 SHALL have ports res_dr, res_di  output  18, res_dv  output  1, res_sync  output  1, res_id  output  1  tagged FFT result.
REQ-010 SHALL have port err_orphan  output  1  sticky: FFT output arrived with no outstanding tag.

Function
REQ-011 SHALL transfer data in blocks of exactly 3 samples per requester; a grant SHALL NOT change inside a block.
REQ-012 SHALL implement states IDLE, BUSY0, BUSY1; IDLE->BUSYk when a requester's valid is high and tag FIFO not full; BUSYk->IDLE after the 3rd accepted sample.
REQ-013 SHALL arbitrate round-robin: in IDLE with both valid, grant the requester not served last; after reset requester 0 has priority.
REQ-014 SHALL assert reqk_ready only in BUSYk; never both readies high in one cycle.
REQ-015 SHALL allow gaps (valid low) inside a block; sample counter (0..2) advances only on accepted samples.
REQ-016 SHALL register accepted samples to fft_din_* with 1-cycle latency; fft_din_dv=1 exactly for accepted samples, else 0 and data held.
REQ-017 SHALL assert fft_sync_in with fft_din_dv on sample index 0 of each block only.
REQ-018 SHALL push the granted requester ID into the tag FIFO on the IDLE->BUSYk transition; full FIFO blocks the transition (no grant).
REQ-019 SHALL count FFT output samples (fft_dout_dv) 0..2, restarting at 0 on fft_sync_out; pop the tag FIFO on output index 2.
REQ-020 SHALL register fft_dout_* to res_dr/res_di/res_dv/res_sync with 1-cycle latency; res_id = tag FIFO head at the input cycle, constant across the 3 outputs.
REQ-021 SHALL, on fft_dout_dv with tag FIFO empty, set err_orphan (sticky until reset), output res_dv with res_id=0, perform no pop.
REQ-022 SHALL handle push and pop in the same cycle with FIFO occupancy unchanged, including when full (pop frees the slot the same cycle for the decision in REQ-018 only from the next cycle).
REQ-023 SHALL impose no latency assumption on the FFT datapath; up to TAG_DEPTH blocks may be in flight.

Reset
REQ-024 SHALL, on rst high, immediately force: state IDLE, counters 0, tag FIFO empty, priority to requester 0, all readies 0, fft_din_* and res_* 0, err_orphan 0.
REQ-025 SHALL discard a partially transferred block on reset mid-block; the first block after reset starts with sync at index 0.
REQ-026 SHALL begin accepting samples no earlier than the second rising clk edge after rst deasserts.

Verification
REQ-027 Single requester: req0 sends 3 samples back-to-back -> fft_din_dv 3 cycles, fft_sync_in on first only; loopback FFT model returns -> res_id=0, res_sync on first result.
REQ-028 Contention: both valid continuously for 4 blocks -> grant order 0,1,0,1; res_id sequence 0,1,0,1 matching data.
REQ-029 Gaps: req1 valid pattern 1,0,0,1,0,1 -> exactly 3 accepted, counter holds during gaps, grant held until 3rd.
REQ-030 Tag full: FFT model stalls outputs, TAG_DEPTH=4 -> 4 blocks accepted, 5th not granted (readies 0) until first output block popped.
REQ-031 Orphan: drive fft_dout_dv with empty FIFO -> err_orphan=1 next cycle, stays 1 until rst.
REQ-032 Reset mid-block: assert rst after 2nd sample of req0 block -> all outputs 0 asynchronously; next block restarts at index 0 with fft_sync_in.
